tpu_host_if: RTL and testbench
==============================

Name: tpu_host_if

Overview:
- Byte-serial host command interface inside tpu_top, directly downstream of the TT pads.
- Decodes ui/uio pad inputs into weight and activation register writes, start and readback commands for the 2x2 systolic array.
- Captures array results into a buffer and returns them one byte at a time on out_ui.
- Owns the uio direction mask and the status bits on the output half of uio.

Parameters:
DATA_W, 8, operand width of each weight/activation element (fixed 8; bus byte = one element)
ACC_W, 16, width of each array result; legal range 9..16
TIMEOUT_CYCLES, 64, watchdog limit in cycles from arr_start (used only with TPU_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
inp_ui  in  8  command data byte (LOAD payload; READ: bit0 = byte select)
inp_uio  in  8  [0] cmd_valid, [2:1] opcode, [4:3] addr, [7:5] ignored
out_ui  out  8  readback byte
out_uio  out  8  [7] rd_valid, [6] busy, [5] err, [4:0] = 0
oe_uio  out  8  constant 8'hE0
arr_w  out  4*DATA_W  weights w0..w3, w0 in LSBs
arr_a  out  4*DATA_W  activations a0..a3, a0 in LSBs
arr_start  out  1  single-cycle compute start pulse
arr_done  in  1  array completion strobe; arr_result valid in the same cycle
arr_result  in  4*ACC_W  results r0..r3, r0 in LSBs

Behaviour:
- Reset (async assert, sync-release use of clk): all weight/activation/result registers 0; out_ui=0; rd_valid=0, busy=0, err=0; arr_start=0; FSM=IDLE; cmd_valid history register=0. oe_uio=8'hE0 at all times including reset.
- Command accept: cmd_valid is edge-detected against a registered copy; a command is accepted on the cycle where inp_uio[0]=1 and the registered copy is 0. Holding cmd_valid high issues exactly one command.
- Opcodes: 00 LOAD_W, 01 LOAD_A, 10 START, 11 READ.
- LOAD_W/LOAD_A in IDLE: element [addr] <= inp_ui; visible on arr_w/arr_a the next cycle. In WAIT: write dropped, err<=1.
- START in IDLE: err<=0; next cycle arr_start=1 for exactly one cycle, busy=1 and FSM=WAIT. START in WAIT: ignored, err<=1.
- WAIT: on arr_done=1, all four results are latched into the result buffer; FSM->IDLE; busy=0 the next cycle. arr_done outside WAIT is ignored and leaves the buffer unchanged.
- READ (legal in any state): next cycle out_ui = inp_ui[0] ? result[addr][ACC_W-1:8] zero-extended : result[addr][7:0]; rd_valid=1 for that single cycle. out_ui holds its value until the next READ.
- READ during WAIT returns the previous buffer contents.
- arr_w/arr_a are guaranteed stable while busy=1 because LOADs are rejected in WAIT.
- States: IDLE, WAIT (a START register provides the pulse). Latency: command edge -> effect = 1 cycle.
- Reset mid-WAIT: the FSM returns to IDLE immediately; the buffer and operands are cleared; no arr_start is issued after release.

Optional Feature:
- Macro TPU_TIMEOUT_EN.
- Defined: a counter clears at arr_start and increments each WAIT cycle. On reaching TIMEOUT_CYCLES without arr_done: FSM->IDLE, busy=0, err=1, result buffer unchanged. If arr_done coincides with expiry, done wins: results are latched and err is not set.
- Undefined: no counter; WAIT persists until arr_done or reset.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> immediately out_ui=0, out_uio=8'h00, oe_uio=8'hE0, arr_start=0, arr_w=arr_a=0.
- Load/compute/read: LOAD_W w0..w3=1,2,3,4; LOAD_A a0..a3=5,6,7,8; START; model returns r0..r3=0x0013,0x0016,0x002B,0x0032 with arr_done after 10 cycles -> arr_start is a one-cycle pulse; busy high until done+1. READ addr0 lo -> out_ui=0x13, rd_valid one cycle; READ addr3 hi -> 0x00.
- Edge detect: hold cmd_valid high for 5 cycles with LOAD_W addr1 data 0x7F, changing inp_ui to 0x11 in cycle 3 -> w1=0x7F; single accept.
- Busy protection: START, then LOAD_A addr0=0xAA and START while busy -> a0 unchanged, no second arr_start, err=1. The next accepted START in IDLE clears err.
- Readback during busy: preload buffer result2=0x1234; START; READ addr2 hi before done -> out_ui=0x12.
- With TPU_TIMEOUT_EN, TIMEOUT_CYCLES=64: START with arr_done never asserted -> busy drops after 64 WAIT cycles, err=1, buffer intact. With arr_done on exactly cycle 64 -> results latched, err=0.

Source files
------------

// File: rtl/tpu_host_if.sv
// Byte-serial host command interface for the 2x2 systolic array: decodes pad commands into
// operand writes, start pulses and result readback. Optional watchdog: define TPU_TIMEOUT_EN.
module tpu_host_if #(
    parameter int DATA_W         = 8,
    parameter int ACC_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            inp_ui,
    input  logic [7:0]            inp_uio,
    output logic [7:0]            out_ui,
    output logic [7:0]            out_uio,
    output logic [7:0]            oe_uio,
    output logic [4*DATA_W-1:0]   arr_w,
    output logic [4*DATA_W-1:0]   arr_a,
    output logic                  arr_start,
    input  logic                  arr_done,
    input  logic [4*ACC_W-1:0]    arr_result
);

    localparam logic [1:0] OP_LOAD_W = 2'b00;
    localparam logic [1:0] OP_LOAD_A = 2'b01;
    localparam logic [1:0] OP_START  = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state;
    logic                cmd_prev;
    logic [DATA_W-1:0]   w_reg   [4];
    logic [DATA_W-1:0]   a_reg   [4];
    logic [ACC_W-1:0]    res_buf [4];
    logic                rd_valid;
    logic                busy;
    logic                err;
    logic                start_q;
    logic [7:0]          rd_byte;

    // Handshake: the host raises cmd_valid (inp_uio[0]) with opcode/addr/data stable; exactly
    // one command is taken on the rising edge of cmd_valid, and it must drop before the next.
    logic                cmd_accept;
    logic [1:0]          opcode;
    logic [1:0]          addr;
    logic [15:0]         rd_ext;
    logic [7:0]          rd_sel;

    assign cmd_accept = inp_uio[0] & ~cmd_prev;
    assign opcode     = inp_uio[2:1];
    assign addr       = inp_uio[4:3];

    // Results narrower than 16 bits read back zero-extended in the high byte.
    assign rd_ext = 16'(res_buf[addr]);
    assign rd_sel = inp_ui[0] ? rd_ext[15:8] : rd_ext[7:0];

    localparam logic [31:0] TO_LIM32 = 32'(TIMEOUT_CYCLES);
    logic unused_bits;
    assign unused_bits = ^{inp_uio[7:5], TO_LIM32};

`ifdef TPU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cmd_prev <= 1'b0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            start_q  <= 1'b0;
            rd_byte  <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                w_reg[i]   <= '0;
                a_reg[i]   <= '0;
                res_buf[i] <= '0;
            end
`ifdef TPU_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            cmd_prev <= inp_uio[0];
            start_q  <= 1'b0;
            rd_valid <= 1'b0;

            if (cmd_accept) begin
                case (opcode)
                    OP_LOAD_W: begin
                        if (state == ST_IDLE) w_reg[addr] <= DATA_W'(inp_ui);
                        else                  err <= 1'b1;
                    end
                    OP_LOAD_A: begin
                        if (state == ST_IDLE) a_reg[addr] <= DATA_W'(inp_ui);
                        else                  err <= 1'b1;
                    end
                    OP_START: begin
                        if (state == ST_IDLE) begin
                            err     <= 1'b0;
                            start_q <= 1'b1;
                            busy    <= 1'b1;
                            state   <= ST_WAIT;
`ifdef TPU_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_READ: begin
                        rd_byte  <= rd_sel;
                        rd_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // A completion strobe in the same cycle as watchdog expiry is still honoured.
            if (state == ST_WAIT) begin
                if (arr_done) begin
                    for (int i = 0; i < 4; i++) begin
                        res_buf[i] <= arr_result[i*ACC_W +: ACC_W];
                    end
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
`ifdef TPU_TIMEOUT_EN
                else if (wait_cnt == CNT_LAST) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    err   <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
`endif
            end
        end
    end

    assign arr_w     = {w_reg[3], w_reg[2], w_reg[1], w_reg[0]};
    assign arr_a     = {a_reg[3], a_reg[2], a_reg[1], a_reg[0]};
    assign arr_start = start_q;
    assign out_ui    = rd_byte;
    assign out_uio   = {rd_valid, busy, err, 5'b00000};
    assign oe_uio    = 8'hE0;

endmodule

// File: tb/tb_tpu_host_if.sv
// Directed bench for tpu_host_if: reset, load/start/readback, edge detect, busy protection,
// mid-WAIT reset, and the watchdog when TPU_TIMEOUT_EN is defined.
module tb_tpu_host_if;

    localparam logic [1:0] OP_LOAD_W = 2'b00;
    localparam logic [1:0] OP_LOAD_A = 2'b01;
    localparam logic [1:0] OP_START  = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    logic        clk;
    logic        rst_n;
    logic [7:0]  inp_ui;
    logic [7:0]  inp_uio;
    logic [7:0]  out_ui;
    logic [7:0]  out_uio;
    logic [7:0]  oe_uio;
    logic [31:0] arr_w;
    logic [31:0] arr_a;
    logic        arr_start;
    logic        arr_done;
    logic [63:0] arr_result;

    int n_vec;
    int n_err;
    int n_starts;
    int exp_starts;
    logic [7:0] exp_q[$];

    tpu_host_if #(.DATA_W(8), .ACC_W(16), .TIMEOUT_CYCLES(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inp_ui     (inp_ui),
        .inp_uio    (inp_uio),
        .out_ui     (out_ui),
        .out_uio    (out_uio),
        .oe_uio     (oe_uio),
        .arr_w      (arr_w),
        .arr_a      (arr_a),
        .arr_start  (arr_start),
        .arr_done   (arr_done),
        .arr_result (arr_result)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arr_start === 1'b1) n_starts++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one idle edge so the edge detector sees cmd_valid low, then the accepting edge
    task automatic cmd(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] data);
        tick();
        inp_uio = {3'b000, addr, op, 1'b1};
        inp_ui  = data;
        tick();
        inp_uio[0] = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] addr, input logic hi,
                            input logic [7:0] exp_status);
        logic [7:0] exp_byte;
        cmd(OP_READ, addr, {7'b0, hi});
        exp_byte = exp_q.pop_front();
        check(tag, out_ui, exp_byte);
        check({tag, "_status"}, out_uio, exp_status);
    endtask

    task automatic done_pulse(input logic [63:0] r);
        arr_result = r;
        arr_done   = 1'b1;
        tick();
        arr_done   = 1'b0;
    endtask

    // array model: 2x2 matrix product of W (row-major w0..w3) and A (row-major a0..a3)
    function automatic logic [63:0] mm(input logic [31:0] w, input logic [31:0] a);
        logic [15:0] r0, r1, r2, r3;
        r0 = 16'(w[7:0])   * 16'(a[7:0])  + 16'(w[15:8])  * 16'(a[23:16]);
        r1 = 16'(w[7:0])   * 16'(a[15:8]) + 16'(w[15:8])  * 16'(a[31:24]);
        r2 = 16'(w[23:16]) * 16'(a[7:0])  + 16'(w[31:24]) * 16'(a[23:16]);
        r3 = 16'(w[23:16]) * 16'(a[15:8]) + 16'(w[31:24]) * 16'(a[31:24]);
        return {r3, r2, r1, r0};
    endfunction

    initial begin
        n_vec      = 0;
        n_err      = 0;
        n_starts   = 0;
        exp_starts = 0;
        rst_n      = 1'b0;
        inp_ui     = 8'h00;
        inp_uio    = 8'h00;
        arr_done   = 1'b0;
        arr_result = 64'h0;

        #1;
        check("rst_out_ui", out_ui, 8'h00);
        check("rst_out_uio", out_uio, 8'h00);
        check("rst_oe_uio", oe_uio, 8'hE0);
        check("rst_arr_start", arr_start, 1'b0);
        check("rst_arr_w", arr_w, 32'h0);
        check("rst_arr_a", arr_a, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // load operands
        cmd(OP_LOAD_W, 2'd0, 8'd1);
        check("w0_next_cycle", arr_w, 32'h0000_0001);
        cmd(OP_LOAD_W, 2'd1, 8'd2);
        cmd(OP_LOAD_W, 2'd2, 8'd3);
        cmd(OP_LOAD_W, 2'd3, 8'd4);
        cmd(OP_LOAD_A, 2'd0, 8'd5);
        cmd(OP_LOAD_A, 2'd1, 8'd6);
        cmd(OP_LOAD_A, 2'd2, 8'd7);
        cmd(OP_LOAD_A, 2'd3, 8'd8);
        check("arr_w_loaded", arr_w, 32'h0403_0201);
        check("arr_a_loaded", arr_a, 32'h0807_0605);

        // compute
        cmd(OP_START, 2'd0, 8'h00);
        exp_starts++;
        check("start_pulse", arr_start, 1'b1);
        check("start_busy", out_uio, 8'h40);
        tick();
        check("start_pulse_end", arr_start, 1'b0);
        repeat (8) tick();
        check("busy_before_done", out_uio, 8'h40);
        done_pulse(mm(arr_w, arr_a));
        check("busy_after_done", out_uio, 8'h00);
        check("one_start", n_starts, exp_starts);

        exp_q.push_back(8'h13);
        read_chk("rd_r0_lo", 2'd0, 1'b0, 8'h80);
        tick();
        check("rd_valid_drop", out_uio, 8'h00);
        check("out_ui_hold", out_ui, 8'h13);
        exp_q.push_back(8'h00);
        read_chk("rd_r3_hi", 2'd3, 1'b1, 8'h80);
        exp_q.push_back(8'h2B);
        read_chk("rd_r2_lo", 2'd2, 1'b0, 8'h80);
        exp_q.push_back(8'h16);
        read_chk("rd_r1_lo", 2'd1, 1'b0, 8'h80);
        exp_q.push_back(8'h32);
        read_chk("rd_r3_lo", 2'd3, 1'b0, 8'h80);

        // edge detect: cmd_valid held five cycles, data changes mid-hold
        tick();
        inp_uio = {3'b000, 2'd1, OP_LOAD_W, 1'b1};
        inp_ui  = 8'h7F;
        tick();
        tick();
        inp_ui = 8'h11;
        repeat (3) tick();
        inp_uio[0] = 1'b0;
        tick();
        check("edge_single_accept", arr_w, 32'h0403_7F01);

        // busy protection
        cmd(OP_START, 2'd0, 8'h00);
        exp_starts++;
        check("busy_set", out_uio, 8'h40);
        cmd(OP_LOAD_A, 2'd0, 8'hAA);
        check("load_in_wait_dropped", arr_a, 32'h0807_0605);
        check("load_in_wait_err", out_uio, 8'h60);
        cmd(OP_START, 2'd0, 8'h00);
        check("start_in_wait_no_pulse", arr_start, 1'b0);
        exp_q.push_back(8'h2B);
        read_chk("rd_prev_during_wait", 2'd2, 1'b0, 8'hE0);
        tick();
        check("start_in_wait_count", n_starts, exp_starts);
        done_pulse({16'h00FF, 16'h1234, 16'h0BCD, 16'h00AA});
        check("err_persists_idle", out_uio, 8'h20);

        // readback during busy
        cmd(OP_START, 2'd0, 8'h00);
        exp_starts++;
        check("start_clears_err", out_uio, 8'h40);
        exp_q.push_back(8'h12);
        read_chk("rd_r2_hi_busy", 2'd2, 1'b1, 8'hC0);
        exp_q.push_back(8'h0B);
        read_chk("rd_r1_hi_busy", 2'd1, 1'b1, 8'hC0);
        done_pulse({16'h0404, 16'h0303, 16'h0202, 16'h0101});
        check("idle_after_done2", out_uio, 8'h00);
        exp_q.push_back(8'h04);
        read_chk("rd_new_r3_lo", 2'd3, 1'b0, 8'h80);

        // arr_done outside WAIT is ignored
        done_pulse({4{16'hFFFF}});
        exp_q.push_back(8'h01);
        read_chk("done_idle_ignored_lo", 2'd0, 1'b0, 8'h80);
        exp_q.push_back(8'h01);
        read_chk("done_idle_ignored_hi", 2'd0, 1'b1, 8'h80);
        check("start_count_mid", n_starts, exp_starts);

`ifdef TPU_TIMEOUT_EN
        cmd(OP_START, 2'd0, 8'h00);
        exp_starts++;
        repeat (63) tick();
        check("to_busy_cycle64", out_uio, 8'h40);
        tick();
        check("to_expired", out_uio, 8'h20);
        exp_q.push_back(8'h04);
        read_chk("to_buffer_intact", 2'd3, 1'b0, 8'hA0);

        cmd(OP_START, 2'd0, 8'h00);
        exp_starts++;
        check("to2_start", out_uio, 8'h40);
        repeat (63) tick();
        done_pulse({16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A});
        check("to_done_wins", out_uio, 8'h00);
        exp_q.push_back(8'h0A);
        read_chk("to_done_latched", 2'd0, 1'b0, 8'h80);
`endif

        // reset in the middle of WAIT
        cmd(OP_START, 2'd0, 8'h00);
        exp_starts++;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_ui", out_ui, 8'h00);
        check("midrst_out_uio", out_uio, 8'h00);
        check("midrst_oe_uio", oe_uio, 8'hE0);
        check("midrst_arr_w", arr_w, 32'h0);
        check("midrst_arr_a", arr_a, 32'h0);
        check("midrst_arr_start", arr_start, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        check("midrst_no_start", n_starts, exp_starts);
        check("midrst_idle", out_uio, 8'h00);
        exp_q.push_back(8'h00);
        read_chk("midrst_buf_cleared", 2'd2, 1'b1, 8'h80);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
